// File: rtl/cronometro_multi_incremento.sv
// N-player chess clock with Fischer increment, pause and per-player timeout flags.
// Times are kept in binary mm:ss and exported as BCD for the display driver.
module cronometro_multi_incremento #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int N_JOG      = 2,
    parameter int INC_MAX    = 59
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carga,
    input  logic                   pausa,
    input  logic [N_JOG-1:0]       j_int,
    input  logic [6:0]             chaves,
    input  logic [5:0]             inc,
    output logic [N_JOG-1:0]       ativo,
    output logic [2:0]             estado,
    output logic [N_JOG-1:0]       j_fim,
    output logic [16*N_JOG-1:0]    tempo_bcd
);

    localparam int PW = $clog2(CLOCK_FREQ);
    localparam int AW = $clog2(N_JOG);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_FREQ - 1);
    localparam logic [5:0]    INC_LIM    = 6'(INC_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_END    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        min_q [N_JOG];
    logic [6:0]        min_d [N_JOG];
    logic [5:0]        sec_q [N_JOG];
    logic [5:0]        sec_d [N_JOG];
    logic [5:0]        inc_q, inc_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [N_JOG-1:0]  ativo_q, ativo_d;
    logic [N_JOG-1:0]  fim_q, fim_d;
    logic [PW-1:0]     presc_q, presc_d;

    logic              tick_s;
    logic              valid_press_s;
    logic              cur_zero_s;
    logic [6:0]        cur_min_s;
    logic [5:0]        cur_sec_s;
    logic [AW-1:0]     first_k_s;
    logic [12:0]       t_dec_s;
    logic [12:0]       t_new_s;

    function automatic logic [12:0] dec_time(input logic [6:0] m, input logic [5:0] s);
        logic [12:0] r;
        if (s != 6'd0) begin
            r = {m, s - 6'd1};
        end else if (m != 7'd0) begin
            r = {m - 7'd1, 6'd59};
        end else begin
            r = {7'd0, 6'd0};
        end
        return r;
    endfunction

    // Adds the increment with a single possible carry (both operands <= 59), saturating at 99:59.
    function automatic logic [12:0] add_time(input logic [6:0] m, input logic [5:0] s,
                                              input logic [5:0] i);
        logic [6:0] sum;
        logic [6:0] ss;
        logic [7:0] mm;
        sum = {1'b0, s} + {1'b0, i};
        ss  = (sum >= 7'd60) ? sum - 7'd60 : sum;
        mm  = (sum >= 7'd60) ? {1'b0, m} + 8'd1 : {1'b0, m};
        return (mm > 8'd99) ? {7'd99, 6'd59} : {mm[6:0], ss[5:0]};
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
        return (i == AW'(N_JOG - 1)) ? {AW{1'b0}} : i + AW'(1);
    endfunction

    function automatic logic [N_JOG-1:0] one_hot(input logic [AW-1:0] i);
        logic [N_JOG-1:0] oh;
        oh    = {N_JOG{1'b0}};
        oh[i] = 1'b1;
        return oh;
    endfunction

    assign tick_s        = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    assign cur_min_s     = min_q[idx_q];
    assign cur_sec_s     = sec_q[idx_q];
    assign cur_zero_s    = (cur_min_s == 7'd0) && (cur_sec_s == 6'd0);
    assign valid_press_s = j_int[idx_q];

    // Next-state logic: load has priority, then the per-state game rules.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        inc_d     = inc_q;
        idx_d     = idx_q;
        ativo_d   = ativo_q;
        fim_d     = fim_q;
        presc_d   = presc_q;
        first_k_s = {AW{1'b0}};
        t_dec_s   = {cur_min_s, cur_sec_s};
        t_new_s   = {cur_min_s, cur_sec_s};

        for (int k = N_JOG - 1; k >= 0; k--) begin
            first_k_s = j_int[k] ? AW'(k) : first_k_s;
        end

        if (carga) begin
            state_d = S_LOADED;
            for (int k = 0; k < N_JOG; k++) begin
                min_d[k] = (chaves > 7'd99) ? 7'd99 : chaves;
                sec_d[k] = 6'd0;
            end
            inc_d   = (inc > INC_LIM) ? INC_LIM : inc;
            idx_d   = {AW{1'b0}};
            ativo_d = {N_JOG{1'b0}};
            fim_d   = {N_JOG{1'b0}};
            presc_d = {PW{1'b0}};
        end else begin
            case (state_q)
                S_LOADED: begin
                    if (|j_int) begin
                        state_d = S_RUN;
                        idx_d   = next_idx(first_k_s);
                        ativo_d = one_hot(next_idx(first_k_s));
                    end else begin
                        state_d = S_LOADED;
                    end
                end
                S_RUN: begin
                    if (cur_zero_s && !valid_press_s) begin
                        state_d       = S_END;
                        fim_d[idx_q]  = 1'b1;
                        ativo_d       = {N_JOG{1'b0}};
                        presc_d       = {PW{1'b0}};
                    end else if (pausa) begin
                        state_d = S_PAUSE;
                    end else begin
                        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
                        t_dec_s = tick_s ? dec_time(cur_min_s, cur_sec_s) : {cur_min_s, cur_sec_s};
                        t_new_s = valid_press_s ? add_time(t_dec_s[12:6], t_dec_s[5:0], inc_q) : t_dec_s;
                        min_d[idx_q] = t_new_s[12:6];
                        sec_d[idx_q] = t_new_s[5:0];
                        if (valid_press_s) begin
                            idx_d   = next_idx(idx_q);
                            ativo_d = one_hot(next_idx(idx_q));
                        end else begin
                            idx_d   = idx_q;
                        end
                    end
                end
                S_PAUSE: begin
                    if (pausa) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int k = 0; k < N_JOG; k++) begin
                min_q[k] <= 7'd0;
                sec_q[k] <= 6'd0;
            end
            inc_q   <= 6'd0;
            idx_q   <= {AW{1'b0}};
            ativo_q <= {N_JOG{1'b0}};
            fim_q   <= {N_JOG{1'b0}};
            presc_q <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            inc_q   <= inc_d;
            idx_q   <= idx_d;
            ativo_q <= ativo_d;
            fim_q   <= fim_d;
            presc_q <= presc_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_JOG; g++) begin : g_bcd
            assign tempo_bcd[16*g +: 16] = {to_bcd(min_q[g]), to_bcd({1'b0, sec_q[g]})};
        end
    endgenerate

    assign estado = state_q;
    assign ativo  = ativo_q;
    assign j_fim  = fim_q;

endmodule

// File: tb/tb_cronometro_multi_incremento.sv
// Directed bench for the 3-player chess clock with a 10-cycle tick.
module tb_cronometro_multi_incremento;

    logic        clock = 1'b0;
    logic        reset;
    logic        carga;
    logic        pausa;
    logic [2:0]  j_int;
    logic [6:0]  chaves;
    logic [5:0]  inc;
    logic [2:0]  ativo;
    logic [2:0]  estado;
    logic [2:0]  j_fim;
    logic [47:0] tempo_bcd;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    cronometro_multi_incremento #(
        .CLOCK_FREQ (10),
        .N_JOG      (3),
        .INC_MAX    (59)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .carga     (carga),
        .pausa     (pausa),
        .j_int     (j_int),
        .chaves    (chaves),
        .inc       (inc),
        .ativo     (ativo),
        .estado    (estado),
        .j_fim     (j_fim),
        .tempo_bcd (tempo_bcd)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pt(input int k);
        return tempo_bcd[16*k +: 16];
    endfunction

    task automatic pulse_j(input logic [2:0] v);
        j_int = v;
        @(negedge clock);
        j_int = 3'b000;
    endtask

    task automatic pulse_pausa();
        pausa = 1'b1;
        @(negedge clock);
        pausa = 1'b0;
    endtask

    task automatic load(input logic [6:0] m, input logic [5:0] i);
        chaves = m;
        inc    = i;
        carga  = 1'b1;
        @(negedge clock);
        carga  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; carga = 1'b0; pausa = 1'b0; j_int = 3'b000;
        chaves = 7'd0; inc = 6'd0;
        repeat (2) @(negedge clock);
        check("rst_estado", 48'(estado), 48'h0);
        check("rst_tempo",  tempo_bcd,   48'h0);
        check("rst_ativo",  48'(ativo),  48'h0);
        check("rst_fim",    48'(j_fim),  48'h0);
        reset = 1'b0;
        @(negedge clock);

        // Load 02:00 / +5 s
        load(7'd2, 6'd5);
        check("ld_estado", 48'(estado), 48'h1);
        check("ld_tempo",  tempo_bcd,   48'h020002000200);

        // Player 0 starts the game -> player 1 on move
        pulse_j(3'b001);
        check("start_ativo",  48'(ativo),  48'h2);
        check("start_estado", 48'(estado), 48'h2);
        repeat (9) @(negedge clock);
        check("pre_tick_p1", 48'(pt(1)), 48'h0200);
        @(negedge clock);
        check("tick1_p1", 48'(pt(1)), 48'h0159);
        check("tick1_p0", 48'(pt(0)), 48'h0200);
        check("tick1_p2", 48'(pt(2)), 48'h0200);
        repeat (20) @(negedge clock);
        check("tick3_p1", 48'(pt(1)), 48'h0157);

        // Player 1 presses together with player 0: only player 1 counts
        pulse_j(3'b011);
        check("inc_p1",    48'(pt(1)), 48'h0202);
        check("inc_p0",    48'(pt(0)), 48'h0200);
        check("inc_ativo", 48'(ativo), 48'h4);
        pulse_j(3'b001);
        check("ign_ativo", 48'(ativo), 48'h4);
        check("ign_p0",    48'(pt(0)), 48'h0200);
        repeat (8) @(negedge clock);
        check("tick_p2", 48'(pt(2)), 48'h0159);

        // Pause with prescaler at 4, hold 50 cycles, resume
        repeat (4) @(negedge clock);
        pulse_pausa();
        check("pause_estado", 48'(estado), 48'h3);
        pulse_j(3'b100);
        repeat (49) @(negedge clock);
        check("pause_p2",    48'(pt(2)), 48'h0159);
        check("pause_ativo", 48'(ativo), 48'h4);
        check("pause_hold",  48'(estado), 48'h3);
        pulse_pausa();
        check("resume_estado", 48'(estado), 48'h2);
        repeat (5) @(negedge clock);
        check("resume_pre_tick", 48'(pt(2)), 48'h0159);
        @(negedge clock);
        check("resume_tick", 48'(pt(2)), 48'h0158);

        // Zero time, simultaneous start presses: lowest index wins, player 2 flags
        load(7'd0, 6'd0);
        check("z_ld_tempo", tempo_bcd,  48'h0);
        check("z_ld_fim",   48'(j_fim), 48'h0);
        pulse_j(3'b110);
        check("z_start_ativo", 48'(ativo),  48'h4);
        check("z_start_fim",   48'(j_fim),  48'h0);
        @(negedge clock);
        check("z_end_estado", 48'(estado), 48'h4);
        check("z_end_fim",    48'(j_fim),  48'h4);
        check("z_end_ativo",  48'(ativo),  48'h0);
        pausa = 1'b1;
        pulse_j(3'b111);
        pausa = 1'b0;
        @(negedge clock);
        check("z_hold_estado", 48'(estado), 48'h4);
        check("z_hold_fim",    48'(j_fim),  48'h4);
        check("z_hold_tempo",  tempo_bcd,   48'h0);

        // Clamped load and saturating increment
        load(7'd120, 6'd63);
        check("s_ld_tempo", tempo_bcd,  48'h990099009900);
        check("s_ld_fim",   48'(j_fim), 48'h0);
        pulse_j(3'b001);
        repeat (10) @(negedge clock);
        check("s_tick_p1", 48'(pt(1)), 48'h9859);
        pulse_j(3'b010);
        check("s_inc_p1", 48'(pt(1)), 48'h9958);
        pulse_j(3'b100);
        check("s_inc_p2", 48'(pt(2)), 48'h9959);
        pulse_j(3'b001);
        check("s_inc_p0", 48'(pt(0)), 48'h9959);
        pulse_j(3'b010);
        check("s_sat_p1",  48'(pt(1)), 48'h9959);
        check("s_sat_ativo", 48'(ativo), 48'h4);

        // Asynchronous reset in the middle of a game
        reset = 1'b1;
        #1;
        check("ar_estado", 48'(estado), 48'h0);
        check("ar_tempo",  tempo_bcd,   48'h0);
        check("ar_ativo",  48'(ativo),  48'h0);
        check("ar_fim",    48'(j_fim),  48'h0);
        @(negedge clock);
        reset = 1'b0;
        pulse_j(3'b001);
        check("idle_estado", 48'(estado), 48'h0);
        check("idle_ativo",  48'(ativo),  48'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
